// File: rtl/siso_frame_rx_if.sv
// Serial-in / word-out bundle for siso_frame_rx: serial line in, valid/ready word port
// and status pulses out. master = receiver side, slave = line driver / consumer side.
interface siso_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              Si;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    input  Si, data_ready,
    output data_out, data_valid, frame_err, overrun, busy
  );

  modport slave (
    output Si, data_ready,
    input  data_out, data_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/siso_frame_rx.sv
// Serial frame receiver: start(1), DATA_W bits MSB first, optional even parity, stop(0),
// feeding a 2-entry output FIFO. Define SISO_RX_PARITY_EN to add the parity bit and check.
module siso_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  siso_frame_rx_if.master       bus
);
  localparam int CW = $clog2(DATA_W);

`ifdef SISO_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_e;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] mem_q [2];
  logic              rd_q, wr_q;
  logic [1:0]        count_q, count_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              frame_done, good, parity_ok;
  logic              push, pop, full;

`ifdef SISO_RX_PARITY_EN
  assign parity_ok = ~(^shift_q ^ par_q);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_done = 1'b0;
    good       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Si) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d = {shift_q[DATA_W-2:0], bus.Si};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef SISO_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SISO_RX_PARITY_EN
      PARITY: begin
        par_d   = bus.Si;
        state_d = STOP;
      end
`endif
      STOP: begin
        frame_done = 1'b1;
        good       = ~bus.Si & parity_ok;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop on the same edge frees the slot, so a full buffer can still accept the push.
  assign full    = (count_q == 2'd2);
  assign pop     = (count_q != 2'd0) && bus.data_ready;
  assign push    = frame_done && good && (!full || pop);
  assign ovr_d   = frame_done && good && full && !pop;
  assign ferr_d  = frame_done && !good;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      count_q <= count_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      if (push) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
    end
  end

  assign bus.data_out   = mem_q[rd_q];
  assign bus.data_valid = (count_q != 2'd0);
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_siso_frame_rx.sv
// Bench for siso_frame_rx: directed scenarios plus random frames, checked each cycle
// against a frame-collecting reference model with a queue standing in for the FIFO.
module tb_siso_frame_rx;
  localparam int DW = 8;
`ifdef SISO_RX_PARITY_EN
  localparam int FL = DW + 3;
`else
  localparam int FL = DW + 2;
`endif

  logic clk = 1'b0;
  logic rst;
  siso_frame_rx_if #(.DATA_W(DW)) bus ();

  siso_frame_rx #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit              txq[$];
  bit              fb[$];
  logic [DW-1:0]   mq[$];
  logic            e_dv, e_fe, e_ov, e_bz;
  logic [DW-1:0]   e_do;

  // Reference: collect a whole frame once a 1 is seen on an idle line, judge it when
  // FL bits are in, and keep accepted words in a queue of depth 2.
  task automatic step(input bit si, input bit rdy, input bit r);
    logic [DW-1:0] w;
    bit good, done, pop;
    @(negedge clk);
    bus.Si = si;
    bus.data_ready = rdy;
    rst = r;
    @(posedge clk);
    e_fe = 1'b0;
    e_ov = 1'b0;
    if (r) begin
      mq.delete();
      fb.delete();
    end else begin
      pop  = (mq.size() > 0) && rdy;
      done = 1'b0;
      good = 1'b0;
      w    = '0;
      if (fb.size() > 0 || si) fb.push_back(si);
      if (fb.size() == FL) begin
        for (int i = 1; i <= DW; i++) w = {w[DW-2:0], fb[i]};
        good = (fb[FL-1] == 1'b0);
`ifdef SISO_RX_PARITY_EN
        if (((^w) ^ fb[DW+1]) != 1'b0) good = 1'b0;
`endif
        done = 1'b1;
        fb.delete();
      end
      if (pop) void'(mq.pop_front());
      if (done) begin
        if (!good) e_fe = 1'b1;
        else if (mq.size() < 2) mq.push_back(w);
        else e_ov = 1'b1;
      end
    end
    e_bz = (fb.size() > 0);
    e_dv = (mq.size() > 0);
    e_do = e_dv ? mq[0] : '0;
    #1;
  endtask

  task automatic mk_frame(input logic [DW-1:0] w, input bit perr, input bit serr);
    txq.push_back(1'b1);
    for (int i = DW - 1; i >= 0; i--) txq.push_back(w[i]);
`ifdef SISO_RX_PARITY_EN
    txq.push_back((^w) ^ perr);
`endif
    txq.push_back(serr);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== 4'b0000 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL reset: vfob=%b%b%b%b dout=%h, want 0000 00", bus.data_valid, bus.frame_err,
               bus.overrun, bus.busy, bus.data_out);
    end
  endtask

  task automatic test_good_frame();
    int nv = 0;
    int nerr = 0;
    logic [DW-1:0] got = '0;
    mk_frame(8'hA5, 1'b0, 1'b0);
    repeat (3) txq.push_back(1'b0);
    while (txq.size() > 0) begin
      step(txq.pop_front(), 1'b1, 1'b0);
      checks++;
      if ({bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== {e_dv, e_fe, e_ov, e_bz} ||
          (e_dv && bus.data_out !== e_do)) begin
        errors++;
        $display("FAIL good_frame cycle: vfob=%b%b%b%b dout=%h, want %b%b%b%b %h", bus.data_valid,
                 bus.frame_err, bus.overrun, bus.busy, bus.data_out, e_dv, e_fe, e_ov, e_bz, e_do);
      end
      if (bus.data_valid) begin nv++; got = bus.data_out; end
      if (bus.frame_err || bus.overrun) nerr++;
    end
    checks++;
    if (nv != 1 || got !== 8'hA5 || nerr != 0) begin
      errors++;
      $display("FAIL good_frame result: valid_cycles=%0d word=%h err_pulses=%0d, want 1 a5 0", nv, got, nerr);
    end
  endtask

  task automatic test_parity_err();
    int nv = 0;
    int nfe = 0;
    logic [DW-1:0] w = 8'hA5;
    txq.push_back(1'b1);
    for (int i = DW - 1; i >= 0; i--) txq.push_back(w[i]);
    txq.push_back(1'b1);
    txq.push_back(1'b0);
    repeat (3) txq.push_back(1'b0);
    while (txq.size() > 0) begin
      step(txq.pop_front(), 1'b1, 1'b0);
      checks++;
      if ({bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== {e_dv, e_fe, e_ov, e_bz} ||
          (e_dv && bus.data_out !== e_do)) begin
        errors++;
        $display("FAIL parity_err cycle: vfob=%b%b%b%b dout=%h, want %b%b%b%b %h", bus.data_valid,
                 bus.frame_err, bus.overrun, bus.busy, bus.data_out, e_dv, e_fe, e_ov, e_bz, e_do);
      end
      if (bus.data_valid) nv++;
      if (bus.frame_err) nfe++;
    end
    checks++;
    if (nv != 0 || nfe != 1) begin
      errors++;
      $display("FAIL parity_err result: valid_cycles=%0d frame_err_pulses=%0d, want 0 1", nv, nfe);
    end
  endtask

  task automatic test_back_to_back();
    int nov = 0;
    logic [DW-1:0] got[$];
    mk_frame(8'h3C, 1'b0, 1'b0);
    mk_frame(8'hC3, 1'b0, 1'b0);
    mk_frame(8'h0F, 1'b0, 1'b0);
    repeat (2) txq.push_back(1'b0);
    while (txq.size() > 0) begin
      step(txq.pop_front(), 1'b0, 1'b0);
      checks++;
      if ({bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== {e_dv, e_fe, e_ov, e_bz} ||
          (e_dv && bus.data_out !== e_do)) begin
        errors++;
        $display("FAIL back_to_back cycle: vfob=%b%b%b%b dout=%h, want %b%b%b%b %h", bus.data_valid,
                 bus.frame_err, bus.overrun, bus.busy, bus.data_out, e_dv, e_fe, e_ov, e_bz, e_do);
      end
      if (bus.overrun) nov++;
    end
    repeat (4) begin
      if (bus.data_valid) got.push_back(bus.data_out);
      step(1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (nov != 1 || got.size() != 2 || got[0] !== 8'h3C || got[1] !== 8'hC3) begin
      errors++;
      $display("FAIL back_to_back result: overruns=%0d popped=%0d first=%h second=%h, want 1 2 3c c3",
               nov, got.size(), got.size() > 0 ? got[0] : 8'h00, got.size() > 1 ? got[1] : 8'h00);
    end
  endtask

  task automatic test_full_pop();
    int nov = 0;
    int n;
    logic [DW-1:0] got[$];
    mk_frame(8'h3C, 1'b0, 1'b0);
    mk_frame(8'hC3, 1'b0, 1'b0);
    mk_frame(8'h81, 1'b0, 1'b0);
    n = txq.size();
    for (int i = 0; i < n; i++) begin
      step(txq.pop_front(), (i == n - 1), 1'b0);
      checks++;
      if ({bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== {e_dv, e_fe, e_ov, e_bz} ||
          (e_dv && bus.data_out !== e_do)) begin
        errors++;
        $display("FAIL full_pop cycle: vfob=%b%b%b%b dout=%h, want %b%b%b%b %h", bus.data_valid,
                 bus.frame_err, bus.overrun, bus.busy, bus.data_out, e_dv, e_fe, e_ov, e_bz, e_do);
      end
      if (bus.overrun) nov++;
    end
    repeat (4) begin
      if (bus.data_valid) got.push_back(bus.data_out);
      step(1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (nov != 0 || got.size() != 2 || got[0] !== 8'hC3 || got[1] !== 8'h81) begin
      errors++;
      $display("FAIL full_pop result: overruns=%0d popped=%0d first=%h second=%h, want 0 2 c3 81",
               nov, got.size(), got.size() > 0 ? got[0] : 8'h00, got.size() > 1 ? got[1] : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    logic [DW-1:0] got = '0;
    logic [DW-1:0] w = 8'hF0;
    mk_frame(8'h99, 1'b0, 1'b0);
    txq.push_back(1'b1);
    for (int i = DW - 1; i >= DW - 4; i--) txq.push_back(w[i]);
    while (txq.size() > 0) step(txq.pop_front(), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b, want 0 0", bus.busy, bus.data_valid);
    end
    mk_frame(8'h5A, 1'b0, 1'b0);
    repeat (3) txq.push_back(1'b0);
    while (txq.size() > 0) begin
      step(txq.pop_front(), 1'b1, 1'b0);
      checks++;
      if ({bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== {e_dv, e_fe, e_ov, e_bz} ||
          (e_dv && bus.data_out !== e_do)) begin
        errors++;
        $display("FAIL reset_mid cycle: vfob=%b%b%b%b dout=%h, want %b%b%b%b %h", bus.data_valid,
                 bus.frame_err, bus.overrun, bus.busy, bus.data_out, e_dv, e_fe, e_ov, e_bz, e_do);
      end
      if (bus.data_valid) begin nv++; got = bus.data_out; end
    end
    checks++;
    if (nv != 1 || got !== 8'h5A) begin
      errors++;
      $display("FAIL reset_mid result: valid_cycles=%0d word=%h, want 1 5a", nv, got);
    end
  endtask

  task automatic test_idle();
    repeat (20) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if ({bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== 4'b0000) begin
        errors++;
        $display("FAIL idle: vfob=%b%b%b%b, want 0000", bus.data_valid, bus.frame_err,
                 bus.overrun, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(0, 3)) txq.push_back(1'b0);
      mk_frame(DW'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      while (txq.size() > 0) begin
        step(txq.pop_front(), ($urandom_range(0, 1) == 1), 1'b0);
        checks++;
        if ({bus.data_valid, bus.frame_err, bus.overrun, bus.busy} !== {e_dv, e_fe, e_ov, e_bz} ||
            (e_dv && bus.data_out !== e_do)) begin
          errors++;
          $display("FAIL random frame %0d: vfob=%b%b%b%b dout=%h, want %b%b%b%b %h", f,
                   bus.data_valid, bus.frame_err, bus.overrun, bus.busy, bus.data_out,
                   e_dv, e_fe, e_ov, e_bz, e_do);
        end
      end
    end
  endtask

  initial begin
    bus.Si = 1'b0;
    bus.data_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_good_frame();
    test_parity_err();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
